echo_tap_scheduler: RTL
=======================

// Module: echo_tap_scheduler
// PURPOSE
//  Controller that time-shares one delay-line BRAM (external true-dual-port, read-first)
//  between one write and NUM_TAPS delayed reads per audio sample. Each accepted sample is
//  written at the circular write pointer, then one read is issued per tap at its programmed delay.
//  All tap samples are presented together, one frame per sample, to the echo/effects mixer in top_level.
// PARAMETERS
//  RAM_DEPTH  60000  delay-line depth in samples; addresses wrap modulo RAM_DEPTH
//  ADDR_W     16     address / delay width; must satisfy 2**ADDR_W >= RAM_DEPTH
//  NUM_TAPS   4      delayed reads per sample (>=1)
//  RD_LAT     2      BRAM read latency in cycles: address at cycle c -> mem_rdata_in valid at c+RD_LAT
// PORTS
//  clk_in          in   1            system clock; single clock domain
//  rst_n_in        in   1            synchronous, active-low reset
//  audio_valid_in  in   1            one-cycle strobe: new sample on audio_in
//  audio_in        in   16           signed PCM sample
//  store_audio_in  in   1            1 = write sample into delay line; 0 = freeze line (reads still run)
//  cfg_valid_in    in   1            write tap configuration this cycle
//  cfg_tap_in      in   $clog2(NUM_TAPS) (min 1)  tap index being configured
//  cfg_delay_in    in   ADDR_W       tap delay in samples
//  cfg_shift_in    in   4            tap attenuation: arithmetic right shift (used only with TAP_MIX_EN)
//  mem_addr_out    out  ADDR_W       BRAM address (single shared port)
//  mem_we_out      out  1            BRAM write enable
//  mem_wdata_out   out  16           BRAM write data
//  mem_rdata_in    in   16           BRAM read data
//  taps_out        out  16*NUM_TAPS  tap k at [16k+15:16k]; held between frames
//  taps_valid_out  out  1            one-cycle strobe: taps_out/mix_out updated
//  mix_out         out  16           saturated sum of attenuated taps (0 without TAP_MIX_EN)
//  busy_out        out  1            frame in progress; samples arriving now are dropped
//  overrun_out     out  1            sticky: a sample was dropped; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n_in=0 at posedge): state IDLE; wr_ptr=0; all tap delays=0, shifts=0; all outputs 0.
//   Reset mid-frame aborts immediately: mem_we_out deasserts in the next cycle; no taps_valid_out pulse.
//  FSM: IDLE -> WRITE -> READ (NUM_TAPS cycles) -> DRAIN (RD_LAT cycles) -> DONE -> IDLE.
//   IDLE: audio_valid_in=1 latches audio_in and store_audio_in, snapshots the tap delays, enters WRITE.
//   WRITE (t0+1): mem_addr_out=wr_ptr; mem_we_out=latched store; mem_wdata_out=sample;
//     base=wr_ptr. If store=1, wr_ptr <= (wr_ptr+1==RAM_DEPTH) ? 0 : wr_ptr+1; else wr_ptr holds.
//   READ (t0+2 .. t0+1+NUM_TAPS): tap k address issued at t0+2+k, mem_we_out=0;
//     addr = (base>=d) ? base-d : base+RAM_DEPTH-d, where d = min(delay_k, RAM_DEPTH-1).
//     Delay 0 returns the current sample when store=1. When store=0, base is the last written slot + 1,
//     so delay 0 reads the oldest entry.
//   DRAIN: rdata captured into tap k at cycle t0+2+k+RD_LAT.
//   DONE (t0+2+NUM_TAPS+RD_LAT): taps_valid_out=1 for one cycle; taps_out and mix_out update in the same cycle.
//  busy_out=1 in every state except IDLE. audio_valid_in while busy_out=1: sample dropped,
//   overrun_out<=1, FSM unaffected. Samples are accepted again from the first IDLE cycle after DONE.
//  mem_addr_out holds its last value and mem_we_out=0 in IDLE/DRAIN/DONE.
//  Config: cfg_valid_in writes delay/shift of tap cfg_tap_in in any state.
//   Index >= NUM_TAPS is ignored. A frame uses the delays snapshotted in IDLE, so mid-frame writes
//   take effect from the next frame. The shift used for mix_out is the value current at DONE.
//  Default frame length (NUM_TAPS=4, RD_LAT=2): 8 cycles, well under the 48 kHz sample period.
// CONFIGURATION
//  TAP_MIX_EN defined: mix_out = sat16( sum_k (tap_k >>> shift_k) ).
//   Signed accumulator width is 16+$clog2(NUM_TAPS)+1; the result clamps to [-32768, 32767].
//   Computed combinationally from captured taps and registered at DONE.
//  TAP_MIX_EN undefined: no mixing logic; mix_out tied to 16'd0; cfg_shift_in ignored.
// TESTING
//  1) Reset, write 100 samples (value = index), tap0=1, tap1=10 -> after sample 99 taps 98 and 89;
//     taps_valid_out exactly t0+8.
//  2) Wrap: RAM_DEPTH=16 build, 20 samples, tap delay 5 at sample 2 -> address 13 read, returns sample value from slot 13.
//  3) cfg_delay_in=RAM_DEPTH+7 -> clamped to RAM_DEPTH-1; delay 0 with store=1 returns audio_in of same frame.
//  4) audio_valid_in at t0+3 -> sample dropped, overrun_out=1 sticky; frame result unchanged; next valid in IDLE accepted.
//  5) store_audio_in=0 frame -> mem_we_out never asserted, wr_ptr unchanged, taps still produced;
//     rst_n_in low at t0+4 -> no strobe, outputs 0.
//  6) TAP_MIX_EN: four taps of 32767 with shift 0 -> mix_out=32767; shifts 2 -> 4*8191=32764; without macro mix_out=0.

Source files
------------

// File: rtl/echo_tap_scheduler.sv
// Delay-line scheduler: one BRAM write plus NUM_TAPS delayed reads per audio sample.
// Optional TAP_MIX_EN macro adds the saturating attenuated tap mixer on mix_out.
module echo_tap_scheduler #(
    parameter int RAM_DEPTH = 60000,
    parameter int ADDR_W    = 16,
    parameter int NUM_TAPS  = 4,
    parameter int RD_LAT    = 2,
    localparam int TAP_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     audio_valid_in,
    input  logic [15:0]              audio_in,
    input  logic                     store_audio_in,
    input  logic                     cfg_valid_in,
    input  logic [TAP_W-1:0]         cfg_tap_in,
    input  logic [ADDR_W-1:0]        cfg_delay_in,
    input  logic [3:0]               cfg_shift_in,
    output logic [ADDR_W-1:0]        mem_addr_out,
    output logic                     mem_we_out,
    output logic [15:0]              mem_wdata_out,
    input  logic [15:0]              mem_rdata_in,
    output logic [16*NUM_TAPS-1:0]   taps_out,
    output logic                     taps_valid_out,
    output logic [15:0]              mix_out,
    output logic                     busy_out,
    output logic                     overrun_out
);

    localparam int CYC_W = $clog2(NUM_TAPS + RD_LAT + 4) + 1;
    localparam int AW1   = ADDR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CYC_W-1:0] CYC_LAST_READ  = CYC_W'(NUM_TAPS + 1);
    localparam logic [CYC_W-1:0] CYC_LAST_DRAIN = CYC_W'(NUM_TAPS + 1 + RD_LAT);
    localparam logic [AW1-1:0]   DEPTH_X        = AW1'(RAM_DEPTH);

    // Circular address `delay` samples behind base; delay is clamped to RAM_DEPTH-1.
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] delay);
        logic [AW1-1:0] b;
        logic [AW1-1:0] d;
        b = {1'b0, base};
        d = ({1'b0, delay} > (DEPTH_X - AW1'(1))) ? (DEPTH_X - AW1'(1)) : {1'b0, delay};
        if (b >= d) begin
            tap_addr = ADDR_W'(b - d);
        end else begin
            tap_addr = ADDR_W'(b + DEPTH_X - d);
        end
    endfunction

    logic [2:0]              state_q, state_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic                    store_q, store_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    mem_we_q, mem_we_d;
    logic [15:0]             mem_wdata_q, mem_wdata_d;
    logic                    taps_valid_q, taps_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic [16*NUM_TAPS-1:0]  taps_q, taps_d;
    logic [16*NUM_TAPS-1:0]  taps_next_s;
    logic [ADDR_W-1:0]       delay_q [NUM_TAPS];
    logic [ADDR_W-1:0]       delay_d [NUM_TAPS];
    logic [ADDR_W-1:0]       snap_q  [NUM_TAPS];
    logic [ADDR_W-1:0]       snap_d  [NUM_TAPS];
    logic [15:0]             cap_q   [NUM_TAPS];
    logic [15:0]             cap_d   [NUM_TAPS];
    logic [AW1-1:0]          wr_inc_s;
    logic                    frame_end_s;

    assign wr_inc_s    = {1'b0, wr_ptr_q} + AW1'(1);
    assign frame_end_s = (state_q == S_DRAIN) && (cyc_q == CYC_LAST_DRAIN);

    // Tap delay configuration; out-of-range indices match no tap.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            delay_d[k] = (cfg_valid_in && (cfg_tap_in == TAP_W'(k))) ? cfg_delay_in : delay_q[k];
        end
    end

    // Last tap's data arrives in the final DRAIN cycle, so it bypasses the capture register.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            taps_next_s[16*k +: 16] = (k == NUM_TAPS - 1) ? mem_rdata_in : cap_q[k];
        end
    end

    // Frame sequencing, BRAM port drive and read-data capture.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        wr_ptr_d     = wr_ptr_q;
        base_d       = base_q;
        store_d      = store_q;
        snap_d       = snap_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        taps_valid_d = 1'b0;
        taps_d       = taps_q;
        overrun_d    = overrun_q | (audio_valid_in && (state_q != S_IDLE));
        for (int k = 0; k < NUM_TAPS; k++) begin
            cap_d[k] = ((state_q != S_IDLE) && (cyc_q == CYC_W'(k + 2 + RD_LAT))) ? mem_rdata_in
                                                                                : cap_q[k];
        end
        case (state_q)
            S_IDLE: begin
                if (audio_valid_in) begin
                    state_d     = S_WRITE;
                    cyc_d       = CYC_W'(1);
                    store_d     = store_audio_in;
                    snap_d      = delay_q;
                    base_d      = wr_ptr_q;
                    mem_addr_d  = wr_ptr_q;
                    mem_we_d    = store_audio_in;
                    mem_wdata_d = audio_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                state_d    = S_READ;
                cyc_d      = cyc_q + CYC_W'(1);
                mem_addr_d = tap_addr(base_q, snap_q[0]);
                if (store_q) begin
                    wr_ptr_d = (wr_inc_s == DEPTH_X) ? {ADDR_W{1'b0}} : wr_inc_s[ADDR_W-1:0];
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
            end
            S_READ: begin
                cyc_d = cyc_q + CYC_W'(1);
                for (int k = 1; k < NUM_TAPS; k++) begin
                    mem_addr_d = (cyc_q == CYC_W'(k + 1)) ? tap_addr(base_q, snap_q[k]) : mem_addr_d;
                end
                if (cyc_q == CYC_LAST_READ) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (frame_end_s) begin
                    state_d      = S_DONE;
                    taps_valid_d = 1'b1;
                    taps_d       = taps_next_s;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cyc_d   = {CYC_W{1'b0}};
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = {CYC_W{1'b0}};
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            cyc_q        <= {CYC_W{1'b0}};
            wr_ptr_q     <= {ADDR_W{1'b0}};
            base_q       <= {ADDR_W{1'b0}};
            store_q      <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 16'd0;
            taps_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            taps_q       <= {(16*NUM_TAPS){1'b0}};
            for (int k = 0; k < NUM_TAPS; k++) begin
                delay_q[k] <= {ADDR_W{1'b0}};
                snap_q[k]  <= {ADDR_W{1'b0}};
                cap_q[k]   <= 16'd0;
            end
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            wr_ptr_q     <= wr_ptr_d;
            base_q       <= base_d;
            store_q      <= store_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            taps_valid_q <= taps_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            taps_q       <= taps_d;
            for (int k = 0; k < NUM_TAPS; k++) begin
                delay_q[k] <= delay_d[k];
                snap_q[k]  <= snap_d[k];
                cap_q[k]   <= cap_d[k];
            end
        end
    end

    assign mem_addr_out   = mem_addr_q;
    assign mem_we_out     = mem_we_q;
    assign mem_wdata_out  = mem_wdata_q;
    assign taps_out       = taps_q;
    assign taps_valid_out = taps_valid_q;
    assign busy_out       = busy_q;
    assign overrun_out    = overrun_q;

`ifdef TAP_MIX_EN
    localparam int ACC_W = 16 + $clog2(NUM_TAPS) + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic [3:0]              shift_q [NUM_TAPS];
    logic [3:0]              shift_d [NUM_TAPS];
    logic signed [ACC_W-1:0] mix_acc_s;
    logic signed [15:0]      tap_sh_s;
    logic [15:0]             mix_sat_s;
    logic [15:0]             mix_q, mix_d;

    // Shift configuration; the forwarded value makes a write landing at DONE take effect.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            shift_d[k] = (cfg_valid_in && (cfg_tap_in == TAP_W'(k))) ? cfg_shift_in : shift_q[k];
        end
    end

    // Saturating sum of attenuated taps.
    always_comb begin
        mix_acc_s = {ACC_W{1'b0}};
        tap_sh_s  = 16'sd0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            tap_sh_s  = $signed(taps_next_s[16*k +: 16]) >>> shift_d[k];
            mix_acc_s = mix_acc_s + {{(ACC_W-16){tap_sh_s[15]}}, tap_sh_s};
        end
        if (mix_acc_s > SAT_MAX) begin
            mix_sat_s = 16'h7FFF;
        end else if (mix_acc_s < SAT_MIN) begin
            mix_sat_s = 16'h8000;
        end else begin
            mix_sat_s = mix_acc_s[15:0];
        end
        mix_d = frame_end_s ? mix_sat_s : mix_q;
    end

    // Mixer registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            mix_q <= 16'd0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                shift_q[k] <= 4'd0;
            end
        end else begin
            mix_q <= mix_d;
            for (int k = 0; k < NUM_TAPS; k++) begin
                shift_q[k] <= shift_d[k];
            end
        end
    end

    assign mix_out = mix_q;
`else
    logic unused_shift_s;
    assign unused_shift_s = ^cfg_shift_in;
    assign mix_out        = 16'd0;
`endif

endmodule
